// File: rtl/iter_barrel_shifter.sv
// iter_barrel_shifter: sequential barrel shifter applying one binary-weighted
// shift stage per clock (stage k shifts by 2^k when amount bit k is set).
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROL. Results leave on a valid/ready port.
// Optional build macro ITER_SHIFT_SKIP_ZERO_EN: finish as soon as no higher
// amount bits remain set (an amount of 0 goes straight to HOLD at accept).
module iter_barrel_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    logic [1:0]       mode_q;
    logic [SHW-1:0]   k_q;

    logic [SHW:0]     step;
    logic [SHW:0]     back;
    logic [WIDTH-1:0] sra_val;
    logic [WIDTH-1:0] stage_out;
    logic             stage_done;
    logic             accept;
    logic             bypass;

    // One mux layer: shift the data register by 2^k in the captured mode
    always_comb begin
        step    = (SHW+1)'(1) << k_q;
        back    = (SHW+1)'(WIDTH) - step;
        sra_val = $signed(data_q) >>> step;
        stage_out = data_q;
        if (amt_q[k_q]) begin
            case (mode_q)
                2'b00:   stage_out = data_q << step;
                2'b01:   stage_out = data_q >> step;
                2'b10:   stage_out = sra_val;
                default: stage_out = (data_q << step) | (data_q >> back);
            endcase
        end
    end

    // Decide whether the stage applied this cycle is the final one
    always_comb begin
`ifdef ITER_SHIFT_SKIP_ZERO_EN
        stage_done = (k_q == SHW'(SHW-1)) || (((amt_q >> k_q) >> 1) == '0);
        bypass     = (in_amt == '0);
`else
        stage_done = (k_q == SHW'(SHW-1));
        bypass     = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = bypass ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (stage_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-stage data update and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            amt_q    <= '0;
            mode_q   <= '0;
            k_q      <= '0;
            out_data <= '0;
        end else begin
            if (accept) begin
                data_q <= in_data;
                amt_q  <= in_amt;
                mode_q <= in_mode;
                k_q    <= '0;
                if (bypass) begin
                    out_data <= in_data;
                end
            end else if (state == SHIFT) begin
                data_q <= stage_out;
                // k stops at the last applied stage so it never passes SHW-1
                if (stage_done) begin
                    out_data <= stage_out;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
        end
    end

endmodule
